pedestal_subtract_hold: RTL
===========================

# pedestal_subtract_hold

Downstream consumer of the pedestal averager: subtracts the running baseline estimate from the raw ADC stream and produces a pedestal-free, saturated 16-bit signed sample for the self-trigger filters. It freezes the baseline in use while the input departs from it by more than a threshold, plus a holdoff afterwards. This stops pulses from being absorbed into the pedestal while the upstream averager window recovers.

## Interface
- THRESH, 200: excursion threshold in ADC counts, legal range 1..32767; a sample is an excursion when |x − bl_used| > THRESH.
- HOLDOFF, 64: cycles spent in RECOVER before tracking resumes, legal range 1..65535.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  channel enable; low forces idle behaviour (see Operation).
- x  in  16  signed raw ADC sample, one per clk.
- baseline  in  16  signed baseline from the averager; may change at any cycle.
- y  out  16  signed baseline-subtracted, saturated sample.
- hold  out  1  high while the baseline is frozen (HOLD or RECOVER).
- bl_out  out  16  signed baseline currently applied (bl_used).

## Operation
- Internal registers:
  - bl_used (16 s): baseline currently applied.
  - d1 (17 s): bl_used − free difference, d1 = x − bl_used, computed full-width with no overflow.
  - cnt (16 u): holdoff counter.
  - state: TRACK, HOLD or RECOVER.
  - y register.
- Stage 1, every edge: d1 <= sign-extended x − sign-extended bl_used, using the bl_used value before the edge.
- exc, combinational from d1: (d1 > THRESH) or (d1 < −THRESH), evaluated at 17 bits.
- Stage 2, every edge: y <= sat16(d1). d1 > 32767 gives 32767; d1 < −32768 gives −32768; otherwise d1[15:0].
- FSM, with enable high:
  - TRACK: bl_used <= baseline. If exc, go to HOLD; bl_used is not loaded on that edge.
  - HOLD: bl_used frozen. If exc, stay. If not exc, cnt <= HOLDOFF−1 and go to RECOVER.
  - RECOVER: bl_used frozen. exc has priority: go to HOLD and set cnt <= 0. Else if cnt == 0, go to TRACK. Else cnt <= cnt−1.
  - RECOVER therefore lasts exactly HOLDOFF cycles when no excursion occurs.
- Outputs: hold = (state != TRACK), registered. bl_out = bl_used.
- enable low, synchronous, sampled each edge:
  - y <= 0.
  - state <= TRACK, cnt <= 0.
  - bl_used <= baseline.
  - d1 keeps updating.
  - hold is 0 after that edge.
- Reset asserted, at any time including mid-HOLD or mid-RECOVER:
  - Clears immediately: y, d1, bl_used, cnt and hold to 0; state to TRACK.
  - Release is synchronised by the system; the first active edge after release behaves as TRACK.

## Timing
- Latency x → y: 2 clk. x sampled at edge t gives d1 at edge t, and y and the state update at edge t+1.
- Excursion on x at edge t asserts hold after edge t+1. bl_used holds the value it had before edge t+1.
- baseline → bl_used: 1 clk in TRACK. baseline → y: 3 clk.
- Last over-threshold d1 at edge t: the state is RECOVER after t+1 and TRACK after t+1+HOLDOFF. hold falls at that same edge.
- Simultaneous excursion and cnt == 0 in RECOVER: go to HOLD, not TRACK.
- Simultaneous enable low and excursion: enable wins.
- Baseline changes during HOLD or RECOVER are ignored. The latest value is adopted on the first TRACK edge.
- Throughput: one sample per clk, no stalls, no handshake.

## Test plan
- Reset and idle: with reset = 0, all outputs are 0 and hold is 0. Release with enable = 1, x = 1000 and baseline = 1000; y settles to 0 by cycle 3.
- Subtraction latency: with baseline = 500, step x from 500 to 650 at edge t. y = 150 after edge t+1, and hold stays 0 (150 ≤ 200).
- Excursion and holdoff (HOLDOFF = 4):
  - Stimulus: baseline = 500, x = 900 for 3 samples then back to 500, and baseline jumps to 700 during the pulse.
  - Required: hold rises after the first sample's t+1, bl_out stays 500 throughout, and y = 400 on the three pulse outputs.
  - Required: hold falls exactly 4 cycles after RECOVER entry, then bl_out = 700.
- Re-trigger in RECOVER: a second excursion with x = 100 against bl_used = 500 (d1 = −400) during RECOVER cycle 2. The state returns to HOLD, hold stays high, and the holdoff restarts from the full HOLDOFF.
- Saturation: x = 32767 with baseline = −32768 gives y = 32767. x = −32768 with baseline = 32767 gives y = −32768. Both assert hold.
- enable and reset mid-operation: drop enable while in HOLD; y = 0 and hold = 0 after the next edge, and bl_out follows baseline. Separately, assert reset mid-RECOVER; all outputs clear to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pedestal_subtract_hold_if.sv
// -----------------------------------------------------------------------------
// pedestal_subtract_hold_if
//
// Groups the per-sample data path of the pedestal subtractor: raw ADC stream and
// baseline in, pedestal-free sample, hold flag and applied baseline out.
// There is no handshake; one sample moves per clk.
//
// Signals:
//   enable    channel enable (low forces idle behaviour)
//   x         signed raw ADC sample
//   baseline  signed baseline estimate from the averager
//   y         signed baseline-subtracted, saturated sample
//   hold      high while the applied baseline is frozen
//   bl_out    signed baseline currently applied
//
// Modports:
//   master  drives the inputs, observes the outputs (stimulus / upstream side)
//   slave   the subtractor itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface pedestal_subtract_hold_if;
   logic               enable;
   logic signed [15:0] x;
   logic signed [15:0] baseline;
   logic signed [15:0] y;
   logic               hold;
   logic signed [15:0] bl_out;

   modport master (
      output enable,
      output x,
      output baseline,
      input  y,
      input  hold,
      input  bl_out
   );

   modport slave (
      input  enable,
      input  x,
      input  baseline,
      output y,
      output hold,
      output bl_out
   );
endinterface

// File: rtl/pedestal_subtract_hold.sv
// -----------------------------------------------------------------------------
// pedestal_subtract_hold
//
// Subtracts the running baseline from the raw ADC stream and produces a
// saturated 16-bit signed, pedestal-free sample. While the input departs from
// the applied baseline by more than THRESH the baseline is frozen (HOLD), and it
// stays frozen for HOLDOFF further cycles (RECOVER) so that pulses are not
// absorbed into the pedestal while the upstream averager window recovers.
//
// Pipeline:
//   stage 1  d1 = x - bl_used            (17-bit, cannot overflow)
//   stage 2  y  = sat16(d1), FSM update   (excursion decided from d1)
//   Latency x -> y is 2 clk; baseline -> bl_used is 1 clk while tracking.
//
// Parameters:
//   THRESH   excursion threshold in ADC counts, 1..32767
//   HOLDOFF  cycles spent in RECOVER before tracking resumes, 1..65535
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    pedestal_subtract_hold_if.slave (enable, x, baseline, y, hold, bl_out)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pedestal_subtract_hold #(
   parameter int THRESH  = 200,
   parameter int HOLDOFF = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   pedestal_subtract_hold_if.slave  bus
);

   typedef enum logic [1:0] {
      TRACK   = 2'd0,
      HOLD    = 2'd1,
      RECOVER = 2'd2
   } state_t;

   localparam logic signed [16:0] THR_POS    = 17'(THRESH);
   localparam logic signed [16:0] THR_NEG    = -THR_POS;
   localparam logic signed [16:0] SAT_MAX    = 17'sd32767;
   localparam logic signed [16:0] SAT_MIN    = -17'sd32768;
   localparam logic [15:0]        CNT_RELOAD = 16'(HOLDOFF - 1);

   state_t             state;
   logic signed [15:0] bl_used;
   logic signed [16:0] d1;
   logic [15:0]        cnt;
   logic signed [15:0] y_q;
   logic               hold_q;

   logic               exc;
   logic signed [15:0] y_sat;

   // Excursion test on the full 17-bit difference, so a difference that would
   // wrap at 16 bits is still classified correctly. |d1| == THRESH is not an
   // excursion.
   // NOTE: every variable driven in always_comb gets a default at the top of
   // the block; a path that leaves it unassigned would infer a latch.
   always_comb begin
      exc = 1'b0;
      if ((d1 > THR_POS) || (d1 < THR_NEG)) begin
         exc = 1'b1;
      end
   end

   // Clamp the 17-bit difference into the signed 16-bit output range.
   always_comb begin
      y_sat = d1[15:0];
      if (d1 > SAT_MAX) begin
         y_sat = 16'sh7fff;
      end else if (d1 < SAT_MIN) begin
         y_sat = 16'sh8000;
      end
   end

   // Stage 1: difference against the baseline applied before this edge. It
   // keeps running while disabled so the pipeline is primed on re-enable.
   // NOTE: clocked state uses non-blocking assignments only, so every register
   // sees the pre-edge value of every other register regardless of order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d1 <= '0;
      end else begin
         d1 <= {bus.x[15], bus.x} - {bl_used[15], bl_used};
      end
   end

   // Stage 2: output register, baseline selection and freeze FSM.
   // hold is registered alongside the state so it always equals
   // (state != TRACK) after each edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= TRACK;
         bl_used <= '0;
         cnt     <= '0;
         y_q     <= '0;
         hold_q  <= 1'b0;
      end else if (!bus.enable) begin
         // Disabled channel: idle output, follow the baseline, drop any freeze.
         // Takes priority over a simultaneous excursion.
         state   <= TRACK;
         bl_used <= bus.baseline;
         cnt     <= '0;
         y_q     <= '0;
         hold_q  <= 1'b0;
      end else begin
         y_q <= y_sat;
         unique case (state)
            TRACK: begin
               if (exc) begin
                  // Keep the pre-pulse baseline; the averager may already be
                  // contaminated by the sample that triggered this.
                  state  <= HOLD;
                  hold_q <= 1'b1;
               end else begin
                  bl_used <= bus.baseline;
               end
            end
            HOLD: begin
               if (!exc) begin
                  state <= RECOVER;
                  cnt   <= CNT_RELOAD;
               end
            end
            RECOVER: begin
               // A new excursion wins over an expiring holdoff; the holdoff is
               // reloaded in full when HOLD is left again.
               if (exc) begin
                  state <= HOLD;
                  cnt   <= '0;
               end else if (cnt == 16'd0) begin
                  // Baseline is picked up on the first TRACK edge, not here.
                  state  <= TRACK;
                  hold_q <= 1'b0;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state  <= TRACK;
               hold_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.y      = y_q;
   assign bus.hold   = hold_q;
   assign bus.bl_out = bl_used;

endmodule
